// File: rtl/cache_pkg.sv
// Shared types and default sizing for the set-associative cache.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait
  } state_e;

  localparam int unsigned DefWays  = 4;
  localparam int unsigned DefSets  = 16;
  localparam int unsigned DefLineW = 64;
  localparam int unsigned DefAddrW = 16;

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid bit, tag and data line.
module cache_way_array #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned TAG_W  = 12,
  parameter int unsigned LINE_W = 64,
  localparam int unsigned IdxW  = $clog2(SETS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IdxW-1:0]   rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic [SETS-1:0]   wr_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_q | wr_en_i;
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < SETS; s++) begin
      if (wr_en_i[s]) begin
        tag_q[s]  <= wr_tag_i;
        data_q[s] <= wr_data_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/set_assoc_cache.sv
// Blocking set-associative cache: read-allocate, write-hit-only, round-robin replacement.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned WAYS   = DefWays,
  parameter int unsigned SETS   = DefSets,
  parameter int unsigned LINE_W = DefLineW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned WAY_W = $clog2(WAYS);

  state_e            state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [WAY_W-1:0]  rr_q [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   way_valid, hit_way, way_we;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_data [WAYS];
  logic [SETS-1:0]   way_set_we [WAYS];
  logic [LINE_W-1:0] hit_data, wr_data;
  logic [WAY_W-1:0]  victim;
  logic              hit, fill;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_set_we[w] = way_we[w] ? (SETS'(1) << idx) : '0;

    cache_way_array #(
      .SETS  (SETS),
      .TAG_W (TAG_W),
      .LINE_W(LINE_W)
    ) u_way (
      .clk_i     (clk),
      .rst_ni    (gen_reset),
      .rd_idx_i  (idx),
      .rd_valid_o(way_valid[w]),
      .rd_tag_o  (way_tag[w]),
      .rd_data_o (way_data[w]),
      .wr_en_i   (way_set_we[w]),
      .wr_tag_i  (tag),
      .wr_data_i (wr_data)
    );
  end

  always_comb begin
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way[w] = way_valid[w] && (way_tag[w] == tag);
      if (hit_way[w]) hit_data = hit_data | way_data[w];
    end
  end

  assign hit = |hit_way;

  // Lowest invalid way wins; the pointer is only consulted for a full set.
  always_comb begin
    victim = rr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
  end

  assign fill = (state_q == StMissWait) && mem_rsp_valid;

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    way_we        = '0;
    wr_data       = wdata_q;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StLookup;
      end
      StLookup: begin
        if (hit || write_q) begin
          resp_valid = 1'b1;
          resp_hit   = hit;
          state_d    = StIdle;
          if (write_q) way_we = hit_way;
          else         resp_rdata = hit_data;
        end else begin
          state_d = StMissReq;
        end
      end
      StMissReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        if (mem_req_ready) state_d = StMissWait;
      end
      StMissWait: begin
        if (mem_rsp_valid) begin
          resp_valid = 1'b1;
          resp_rdata = mem_rsp_data;
          wr_data    = mem_rsp_data;
          way_we     = WAYS'(1) << victim;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge gen_reset) begin
    if (!gen_reset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (fill && (&way_valid)) rr_q[idx] <= rr_q[idx] + 1'b1;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomized self-checking bench for set_assoc_cache against a set/way reference model.
module tb_set_assoc_cache;

  localparam int unsigned WAYS   = 4;
  localparam int unsigned SETS   = 16;
  localparam int unsigned LINE_W = 64;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IDX_W  = 4;

  logic              clk = 1'b0;
  logic              gen_reset = 1'b0;
  logic              req_valid = 1'b0, req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_wdata = '0;
  logic              req_ready, resp_valid, resp_hit, mem_req_valid;
  logic [LINE_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [LINE_W-1:0] mem_rsp_data = '0;

  set_assoc_cache #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .LINE_W(LINE_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .gen_reset    (gen_reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_rdata   (resp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: what each set holds, plus its replacement pointer.
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [63:0] m_data  [SETS][WAYS];
  int unsigned m_rr    [SETS];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  function automatic int model_find(input logic [ADDR_W-1:0] addr);
    int unsigned s = int'(addr) % SETS;
    int unsigned t = int'(addr) / SETS;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic model_fill(input logic [ADDR_W-1:0] addr, input logic [63:0] data);
    int unsigned s = int'(addr) % SETS;
    int v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = int'(m_rr[s]);
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = int'(addr) / SETS;
    m_data[s][v]  = data;
  endtask

  // Checks the LOOKUP-cycle response for a request the model says is a hit or a write.
  task automatic check_lookup(input bit wr, input logic [ADDR_W-1:0] addr);
    int way = model_find(addr);
    int unsigned s = int'(addr) % SETS;
    check_eq("lookup_resp_valid", 64'(resp_valid), 64'(way >= 0 || wr));
    check_eq("lookup_resp_hit", 64'(resp_hit), 64'(way >= 0));
    if (!wr && way >= 0) check_eq("lookup_rdata", resp_rdata, m_data[s][way]);
  endtask

  // One request from IDLE back to IDLE. A read miss stalls mem_req_ready for
  // `stall` cycles; `abort` resets the cache in MISS_WAIT instead of filling.
  task automatic cache_access(input bit wr, input logic [ADDR_W-1:0] addr,
                              input logic [63:0] wdata, input logic [63:0] fill,
                              input int stall, input bit abort);
    int way = model_find(addr);
    int unsigned s = int'(addr) % SETS;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    #1 check_eq("idle_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    #1;
    check_eq("lookup_req_ready", 64'(req_ready), 64'd0);
    check_eq("lookup_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_lookup(wr, addr);
    if (way >= 0 || wr) begin
      if (wr && way >= 0) m_data[s][way] = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check_eq("post_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("post_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check_eq("post_req_ready", 64'(req_ready), 64'd1);
      return;
    end
    // Keep a stray request alive to show it is not accepted mid-miss.
    req_addr = 16'($urandom);
    req_write = 1'($urandom);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      mem_req_ready = (i == stall);
      #1;
      check_eq("miss_mem_req_valid", 64'(mem_req_valid), 64'd1);
      check_eq("miss_mem_req_addr", 64'(mem_req_addr), 64'(addr));
      check_eq("miss_req_ready", 64'(req_ready), 64'd0);
      check_eq("miss_resp_valid", 64'(resp_valid), 64'd0);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1 check_eq("wait_mem_req_valid", 64'(mem_req_valid), 64'd0);
    if (abort) begin
      gen_reset = 1'b0;
      #1;
      model_reset();
      check_eq("rst_req_ready", 64'(req_ready), 64'd1);
      check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check_eq("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
      check_eq("rst_resp_rdata", resp_rdata, 64'd0);
      @(negedge clk);
      gen_reset = 1'b1; req_valid = 1'b0;
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_data = fill;
      #1 check_eq("late_rsp_resp_valid", 64'(resp_valid), 64'd0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      return;
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = fill;
    #1;
    check_eq("fill_resp_valid", 64'(resp_valid), 64'd1);
    check_eq("fill_resp_hit", 64'(resp_hit), 64'd0);
    check_eq("fill_rdata", resp_rdata, fill);
    model_fill(addr, fill);
    @(negedge clk);
    mem_rsp_valid = 1'b0; req_valid = 1'b0;
    #1;
    check_eq("fill_post_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("fill_post_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic spurious_rsp();
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = {$urandom, $urandom};
    #1 check_eq("spurious_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  // Second read offered while the first response is on the bus.
  task automatic b2b_reads(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a1;
    @(negedge clk);
    req_addr = a2;
    #1 check_lookup(1'b0, a1);
    @(negedge clk);
    #1;
    check_eq("b2b_idle_ready", 64'(req_ready), 64'd1);
    check_eq("b2b_idle_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1 check_lookup(1'b0, a2);
    @(negedge clk);
    #1 check_eq("b2b_post_resp", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_req_ready", 64'(req_ready), 64'd1);
    check_eq("reset_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("reset_resp_hit", 64'(resp_hit), 64'd0);
    check_eq("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_eq("reset_rdata", resp_rdata, 64'd0);
    check_eq("reset_mem_req_addr", 64'(mem_req_addr), 64'd0);
    @(negedge clk);
    gen_reset = 1'b1;

    cache_access(1'b0, 16'h0012, '0, 64'hA5A5_0000_0000_0001, 0, 1'b0);
    cache_access(1'b0, 16'h0012, '0, '0, 0, 1'b0);
    foreach (m_valid[0][w]) cache_access(1'b0, 16'h0013 + 16'(w) * 16'h10, '0,
                                         {$urandom, $urandom}, 1, 1'b0);
    cache_access(1'b0, 16'h0053, '0, 64'h5353, 0, 1'b0);
    cache_access(1'b0, 16'h0013, '0, 64'h1313, 0, 1'b0);
    cache_access(1'b1, 16'h0012, 64'h1111, '0, 0, 1'b0);
    cache_access(1'b0, 16'h0012, '0, '0, 0, 1'b0);
    cache_access(1'b1, 16'h0099, 64'h9999, '0, 0, 1'b0);
    cache_access(1'b0, 16'h0077, '0, 64'h7777, 5, 1'b0);
    b2b_reads(16'h0012, 16'h0043);
    spurious_rsp();
    cache_access(1'b0, 16'h0012, '0, '0, 0, 1'b0);
    cache_access(1'b0, 16'h0088, '0, 64'h8888, 0, 1'b1);
    cache_access(1'b0, 16'h0088, '0, 64'h8889, 0, 1'b0);
    cache_access(1'b0, 16'h0012, '0, 64'h1212, 0, 1'b0);

    // Small tag/index ranges so hits, evictions and wraps all occur often.
    for (int i = 0; i < 300; i++) begin
      a = {9'd0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 19) == 0) spurious_rsp();
      cache_access(($urandom_range(0, 9) < 3), a, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WAYS, 4, associativity, power of two, 2..8 | SETS, 16, sets, power of two | LINE_W, 64, line width in bits | ADDR_W, 16, line address width; IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 gen_reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  high only in IDLE.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_addr  in  ADDR_W  line address; {tag, index}, index = LSBs.
REQ-008 req_wdata  in  LINE_W  write data.
REQ-009 resp_valid  out  1  one-cycle response pulse.
REQ-010 resp_hit  out  1  lookup hit, qualified by resp_valid.
REQ-011 resp_rdata  out  LINE_W  read data, qualified by resp_valid && !req_write of accepted request.
REQ-012 mem_req_valid  out  1  line-fetch request to next level.
REQ-013 mem_req_ready  in  1  next level accepts fetch.
REQ-014 mem_req_addr  out  ADDR_W  address being fetched.
REQ-015 mem_rsp_valid  in  1  fill data present (one cycle).
REQ-016 mem_rsp_data  in  LINE_W  fill line.

Function
REQ-017 FSM states SHALL be IDLE, LOOKUP, MISS_REQ, MISS_WAIT; IDLE->LOOKUP on req_valid&&req_ready, capturing req_write/addr/wdata.
REQ-018 LOOKUP: hit = any way with valid[idx] && tag==captured tag; at most one way SHALL match.
REQ-019 Read hit: resp_valid=1, resp_hit=1, resp_rdata=hit-way data in the LOOKUP cycle (latency 1 after accept); ->IDLE.
REQ-020 Write hit: hit-way line overwritten with wdata at end of LOOKUP; resp_valid=1, resp_hit=1; ->IDLE.
REQ-021 Write miss: no allocation, no memory traffic; resp_valid=1, resp_hit=0; ->IDLE.
REQ-022 Read miss: ->MISS_REQ; mem_req_valid=1, mem_req_addr=captured address, held stable until mem_req_ready; then ->MISS_WAIT.
REQ-023 MISS_WAIT: on mem_rsp_valid, victim way written with mem_rsp_data, tag, valid=1; resp_valid=1, resp_hit=0, resp_rdata=mem_rsp_data same cycle; ->IDLE.
REQ-024 Victim SHALL be lowest-numbered invalid way in the set; if all valid, per-set round-robin pointer way, pointer then increments modulo WAYS (wraps WAYS-1->0).
REQ-025 Round-robin pointer SHALL change only on fill into a fully valid set.
REQ-026 mem_rsp_valid outside MISS_WAIT SHALL be ignored; req_valid outside IDLE SHALL not be accepted.
REQ-027 Back-to-back: request offered in the cycle resp_valid asserts SHALL be accepted on the next cycle (IDLE).
REQ-028 Outputs SHALL be registered or decoded from state/arrays only; no combinational path req_*->resp_*.

Reset
REQ-029 gen_reset low SHALL immediately force IDLE, all valid bits 0, all round-robin pointers 0, resp_valid/resp_hit/mem_req_valid 0, resp_rdata 0, mem_req_addr 0.
REQ-030 Reset mid-miss SHALL abandon the fetch; a later mem_rsp_valid SHALL not write any way.
REQ-031 Data and tag storage SHALL not be reset.

Structure
REQ-032 Package cache_pkg SHALL hold the state enum and default parameter constants.
REQ-033 One sub-module, cache_way_array (tag+valid+data storage for one way, per-set write enable), SHALL be instantiated WAYS times via generate.

Verification
REQ-034 After reset, read 0x0012 -> miss, mem_req_addr=0x0012; reply 0xA5A5_0000_0000_0001 -> resp_hit=0 with that data; re-read 0x0012 -> resp_hit=1, same data, 1 cycle after accept.
REQ-035 Fill 0x0013, 0x0023, 0x0033, 0x0043 (set 3), then 0x0053 -> victim way 0 (pointer 0->1); read 0x0013 -> miss.
REQ-036 Write 0x0012 data 0x1111 after fill -> resp_hit=1; read 0x0012 -> 0x1111; write 0x0099 (absent) -> resp_hit=0, no mem_req_valid.
REQ-037 Hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable; req_ready=0 throughout.
REQ-038 Assert gen_reset low in MISS_WAIT, then pulse mem_rsp_valid -> no fill; read same address -> miss.
REQ-039 Spurious mem_rsp_valid in IDLE -> no state or array change.
